// File: rtl/byte_frame_sequencer.sv
// Sequences a byte-serial datapath: loads an operand frame over a valid/ready
// stream, waits out the datapath register latency, then streams the result bytes.
module byte_frame_sequencer #(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      dp_wr_en,
  output logic [LOG2_BYTES_IN-1:0]  dp_wr_sel,
  output logic [7:0]                dp_wr_data,
  output logic [LOG2_BYTES_OUT-1:0] dp_rd_sel,
  input  logic [7:0]                dp_rd_data,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [7:0]                frame_count
);

  localparam logic [LOG2_BYTES_IN-1:0]  IN_LAST   = '1;
  localparam logic [LOG2_BYTES_OUT-1:0] OUT_LAST  = '1;
  localparam logic [3:0]                WAIT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_UNLOAD} state_t;

  state_t                    r_state, w_state_nxt;
  logic [LOG2_BYTES_IN-1:0]  r_in_cnt, w_in_cnt_nxt;
  logic [LOG2_BYTES_OUT-1:0] r_out_cnt, w_out_cnt_nxt;
  logic [3:0]                r_wait_cnt, w_wait_cnt_nxt;
  logic [7:0]                r_frame_cnt, w_frame_cnt_nxt;

  logic w_in_ready, w_out_valid, w_accept, w_out_hs;

  // Handshake qualifiers depend only on state, flush and rst, never on the
  // partner's valid/ready, so no combinational loop through the streams.
  assign w_in_ready  = (r_state == S_LOAD)   && !flush && !rst;
  assign w_out_valid = (r_state == S_UNLOAD) && !flush && !rst;
  assign w_accept    = in_valid  && w_in_ready;
  assign w_out_hs    = out_ready && w_out_valid;

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign busy        = (r_state != S_LOAD) && !rst;
  assign dp_wr_en    = w_accept;
  assign dp_wr_sel   = r_in_cnt;
  assign dp_wr_data  = in_data;
  assign dp_rd_sel   = r_out_cnt;
  assign out_data    = dp_rd_data;
  assign frame_count = r_frame_cnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_in_cnt_nxt    = r_in_cnt;
    w_out_cnt_nxt   = r_out_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (r_in_cnt == IN_LAST) begin
            w_in_cnt_nxt   = '0;
            w_wait_cnt_nxt = WAIT_INIT;
            w_state_nxt    = S_WAIT;
          end else begin
            w_in_cnt_nxt = r_in_cnt + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_out_cnt_nxt = '0;
          w_state_nxt   = S_UNLOAD;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      S_UNLOAD: begin
        if (w_out_hs) begin
          if (r_out_cnt == OUT_LAST) begin
            w_out_cnt_nxt   = '0;
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
            w_state_nxt     = S_LOAD;
          end else begin
            w_out_cnt_nxt = r_out_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
    // Abort: the handshake is already masked, so frame count cannot advance here.
    if (flush) begin
      w_state_nxt    = S_LOAD;
      w_in_cnt_nxt   = '0;
      w_out_cnt_nxt  = '0;
      w_wait_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_byte_frame_sequencer.sv
// Directed bench for byte_frame_sequencer with a small datapath model:
// result[k] = operand[k] + operand[k+4], registered one cycle after the operand.
module tb_byte_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data, dp_wr_data, dp_rd_data, out_data, frame_count;
  logic       in_ready, dp_wr_en, out_valid, busy;
  logic [2:0] dp_wr_sel;
  logic [1:0] dp_rd_sel;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_frame_sequencer #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dp_wr_en(dp_wr_en), .dp_wr_sel(dp_wr_sel), .dp_wr_data(dp_wr_data),
    .dp_rd_sel(dp_rd_sel), .dp_rd_data(dp_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_count(frame_count)
  );

  logic [7:0] op  [8];
  logic [7:0] res [4];
  always_ff @(posedge clk) begin
    if (dp_wr_en) op[dp_wr_sel] <= dp_wr_data;
    for (int k = 0; k < 4; k++) res[k] <= op[k] + op[k+4];
  end
  assign dp_rd_data = res[dp_rd_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push a full frame with in_valid held; leaves us one step past the last write edge.
  task automatic push(input logic [63:0] ops);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = ops[8*i +: 8];
      #1;
      chk("p_we",  dp_wr_en, 1);
      chk("p_sel", dp_wr_sel, i);
      chk("p_dat", dp_wr_data, ops[8*i +: 8]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_uv();
    int n = 0;
    while (out_valid !== 1'b1 && n < 8) begin tick(); n++; end
    chk("uv_timeout", out_valid, 1);
  endtask

  task automatic drain(input logic [31:0] exp);
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      #1;
      chk("d_vld", out_valid, 1);
      chk("d_sel", dp_rd_sel, k);
      chk("d_dat", out_data, exp[8*k +: 8]);
      if (k == 3) chk("d_inrdy_same", in_ready, 0);
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("d_inrdy_next", in_ready, 1);
    chk("d_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int writes;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    tick(); tick();
    chk("rst_inrdy", in_ready, 0);
    chk("rst_we",    dp_wr_en, 0);
    chk("rst_ovld",  out_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fc",    frame_count, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("post_rst_inrdy", in_ready, 1);

    // Basic frame with exact latency
    push(64'h0807060504030201);
    chk("b_busy", busy, 1);
    chk("b_lat0", out_valid, 0);
    chk("b_inrdy", in_ready, 0);
    tick();
    chk("b_lat1", out_valid, 0);
    tick();
    chk("b_lat2", out_valid, 1);
    drain(32'h0C0A0806);
    chk("b_fc", frame_count, 1);

    // Output back-pressure
    push(64'h8070605040302010);
    wait_uv();
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0;
      #1;
      chk("bp_vld", out_valid, 1);
      chk("bp_dat", out_data, 8'h60);
      chk("bp_sel", dp_rd_sel, 0);
      tick();
    end
    drain(32'hC0A08060);
    chk("bp_fc", frame_count, 2);

    // Gappy input
    writes = 0;
    for (int j = 0; j < 16; j++) begin
      logic [63:0] g;
      g = 64'h8877665544332211;
      in_valid = (j % 2 == 0);
      in_data  = g[8*(j/2) +: 8];
      #1;
      chk("g_we", dp_wr_en, in_valid);
      if (in_valid) chk("g_sel", dp_wr_sel, j/2);
      chk("g_busy", busy, (j == 15));
      if (dp_wr_en) writes++;
      tick();
    end
    in_valid = 1'b0;
    chk("g_writes", writes, 8);
    wait_uv();
    drain(32'hCCAA8866);
    chk("g_fc", frame_count, 3);

    // Flush mid-load
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hFF - 8'(i);
      tick();
    end
    flush = 1'b1; in_data = 8'hEE;
    #1;
    chk("fl_inrdy", in_ready, 0);
    chk("fl_we", dp_wr_en, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_sel0", dp_wr_sel, 0);
    chk("fl_inrdy_after", in_ready, 1);
    push(64'h100F0E0D0C0B0A09);
    wait_uv();
    drain(32'h1C1A1816);
    chk("fl_fc", frame_count, 4);

    // Flush in UNLOAD after two result bytes
    push(64'h0807060504030201);
    wait_uv();
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1;
      #1;
      chk("fu_dat", out_data, (k == 0) ? 8'h06 : 8'h08);
      tick();
    end
    flush = 1'b1;
    #1;
    chk("fu_vld", out_valid, 0);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("fu_inrdy", in_ready, 1);
    chk("fu_busy", busy, 0);
    chk("fu_sel0", dp_rd_sel, 0);
    chk("fu_fc", frame_count, 4);

    // Wrap: 4 -> 255 -> 0 -> 1
    for (int f = 0; f < 251; f++) begin
      push(64'h0807060504030201);
      wait_uv();
      drain(32'h0C0A0806);
    end
    chk("w_fc255", frame_count, 255);
    push(64'h0807060504030201);
    wait_uv();
    drain(32'h0C0A0806);
    chk("w_fc0", frame_count, 0);
    push(64'h0807060504030201);
    wait_uv();
    drain(32'h0C0A0806);
    chk("w_fc1", frame_count, 1);

    // Reset mid-WAIT
    push(64'h0807060504030201);
    chk("r_inwait", busy, 1);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    chk("r_inrdy", in_ready, 0);
    chk("r_we", dp_wr_en, 0);
    chk("r_vld", out_valid, 0);
    chk("r_busy", busy, 0);
    tick();
    chk("r_fc", frame_count, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("r_inrdy_after", in_ready, 1);
    push(64'h8070605040302010);
    wait_uv();
    drain(32'hC0A08060);
    chk("r_fc_after", frame_count, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/byte_frame_sequencer.md
Name: byte_frame_sequencer

Overview:
Controller that sequences the byte-serial test datapath, which has an 8-byte operand register written one byte per clock by select and a registered 4-byte result read back by select. It accepts an operand frame of BYTES_IN bytes over a valid/ready stream and writes each byte into the datapath. It then waits out the datapath's register latency and streams the BYTES_OUT result bytes on an output valid/ready stream. It sits between the top-level pin interface and the datapath, so software no longer drives the byte selects by hand.

Parameters:
LOG2_BYTES_IN, 3, log2 of operand bytes per frame (BYTES_IN = 1<<LOG2_BYTES_IN).
LOG2_BYTES_OUT, 2, log2 of result bytes per frame (BYTES_OUT = 1<<LOG2_BYTES_OUT).
LATENCY, 2, cycles from the last operand write to a valid result (minimum 1, maximum 15).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  sync abort: discard partial frame, return to LOAD
in_data  in  8  operand byte
in_valid  in  1  operand byte present
in_ready  out  1  sequencer accepts operand byte
dp_wr_en  out  1  datapath byte write strobe
dp_wr_sel  out  LOG2_BYTES_IN  datapath operand byte index
dp_wr_data  out  8  datapath operand byte
dp_rd_sel  out  LOG2_BYTES_OUT  datapath result byte index
dp_rd_data  in  8  datapath result byte (combinational mux of registered result)
out_data  out  8  result byte
out_valid  out  1  result byte present
out_ready  in  1  consumer accepts result byte
busy  out  1  high in WAIT or UNLOAD
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- States: LOAD, WAIT, UNLOAD. Reset: state=LOAD, in_cnt=0, out_cnt=0, wait_cnt=0, frame_count=0.
- While rst is high, in_ready, dp_wr_en, out_valid and busy are all 0. The first cycle after reset is in LOAD with in_ready=1.
- LOAD:
  - in_ready=1.
  - Accept occurs when in_valid&in_ready is high.
  - On accept, in the same cycle, combinationally: dp_wr_en=1, dp_wr_sel=in_cnt, dp_wr_data=in_data.
  - in_cnt increments on accept.
  - On accept with in_cnt==BYTES_IN-1: in_cnt<=0, wait_cnt<=LATENCY-1, state<=WAIT.
  - dp_wr_en=0 whenever there is no accept. dp_wr_data=in_data and dp_wr_sel=in_cnt at all times.
- WAIT:
  - in_ready=0, out_valid=0.
  - wait_cnt decrements each cycle. At wait_cnt==0: out_cnt<=0, state<=UNLOAD.
  - Timing: last write on edge N, then out_valid=1 first in the cycle after edge N+LATENCY.
- UNLOAD:
  - out_valid=1, dp_rd_sel=out_cnt, out_data=dp_rd_data.
  - out_data stays stable while out_valid&!out_ready, because no datapath writes occur in this state.
  - On out_ready, out_cnt increments.
  - On out_ready with out_cnt==BYTES_OUT-1: out_cnt<=0, frame_count<=frame_count+1, state<=LOAD. in_ready is 1 the next cycle, not the same cycle.
- dp_rd_sel=out_cnt in all states. out_cnt is 0 outside UNLOAD.
- flush (sync, any state):
  - Next state is LOAD; in_cnt, out_cnt and wait_cnt are cleared; frame_count is unchanged.
  - flush overrides a same-cycle accept: in_ready=0 and dp_wr_en=0 while flush=1.
  - flush overrides a same-cycle out handshake: out_valid=0 while flush=1, and frame_count does not increment.
- Stale operand bytes from an aborted frame remain in the datapath. They are overwritten by the next full frame; a result is never emitted for a partial frame.
- rst has priority over flush. Reset mid-frame behaves identically to a flush and also clears frame_count.
- Back-pressure: in_valid may drop mid-frame; the sequencer waits indefinitely in LOAD. Same for out_ready in UNLOAD.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Basic frame: after reset, push bytes 0x01..0x08 with in_valid held high -> dp_wr_sel 0..7 on consecutive cycles with dp_wr_en=1; out_valid rises exactly 2 cycles after the last write edge; 4 output bytes match the datapath model; frame_count=1.
- Back-pressure: out_ready low for 5 cycles in UNLOAD -> out_valid stays 1, out_data and dp_rd_sel unchanged; then out_ready held high -> bytes 0..3 on 4 consecutive cycles, in_ready=1 the following cycle.
- Gappy input: in_valid toggled 1,0,1,0... over 16 cycles -> exactly 8 writes with dp_wr_sel 0..7, no write while in_valid=0, busy=0 until the 8th accept.
- Flush mid-load: 3 bytes accepted, then flush together with in_valid=1 -> no dp_wr_en that cycle, in_cnt=0; the next 8 bytes produce a correct frame; frame_count increments only once.
- Flush in UNLOAD after 2 output bytes -> out_valid=0 the same cycle, state LOAD, frame_count unchanged.
- Wrap and reset: run 256 frames -> frame_count=0; assert rst mid-WAIT -> outputs 0, frame_count=0, then in_ready=1 the cycle after rst drops.
